systolic_pe_sequencer: RTL
==========================

Name: systolic_pe_sequencer

Overview:
- Job-level controller for a ROWS x COLS systolic grid of pipelined fp16 multiply-accumulate PEs.
- On each start it performs four steps in order:
  - clears the grid;
  - drives skewed read enables to the west (A) and north (B) operand buffers;
  - issues the per-PE done flag that moves each PE into its final reduction steps;
  - waits for the adder pipelines to drain, then sequences row-wise readout of the accumulated results.
- It sits between the job/command logic and the PE array plus its operand buffers.

Parameters:
- ROWS, 4, grid rows (A lanes).
- COLS, 4, grid columns (B lanes).
- K_W, 16, width of k_len.
- PIPE_STAGE, 2, fp mult/add pipeline depth in the PEs.
- DONE_OFFSET, 3, cycles from PE(0,0)'s last A/B read enable to its done flag; covers buffer read latency plus mult pipeline.
- DRAIN_CYCLES, 10, cycles between the last done flag and readout; covers the PE reduction steps.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  K_W  reduction length; latched on an accepted start.
- busy  out  1  high from CLEAR through DONE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse when a start is rejected.
- pe_clear  out  1  synchronous clear to all PEs and buffer read pointers.
- a_rd_en  out  ROWS  per-row A buffer read enable; the buffer injects zero when low.
- b_rd_en  out  COLS  per-column B buffer read enable.
- pe_done_flag  out  ROWS*COLS  per-PE done pulse; bit index i*COLS+j.
- out_valid  out  1  readout row valid.
- out_row_sel  out  $clog2(ROWS)  row being read out.

Behaviour:
- All outputs are registered. Reset value of every output is 0, including counters and state (state resets to IDLE).
- States: IDLE -> CLEAR -> FEED -> DRAIN -> READ -> DONE -> IDLE.
- IDLE, start=1, k_len!=0: latch k_len as K, go to CLEAR.
- IDLE, start=1, k_len==0: pulse err the next cycle, stay in IDLE.
- CLEAR: exactly 1 cycle with pe_clear=1, then FEED with t=0.
- FEED: t increments each cycle, counter width K_W+1.
  - a_rd_en[i]=1 iff i <= t <= i+K-1.
  - b_rd_en[j]=1 iff j <= t <= j+K-1.
  - pe_done_flag[i*COLS+j] pulses for exactly one cycle, at t = K-1+DONE_OFFSET+i+j.
  - FEED ends after t = K-1+DONE_OFFSET+ROWS+COLS-2; the next state is DRAIN.
- DRAIN: exactly DRAIN_CYCLES cycles, all enables 0.
- READ: ROWS cycles with out_valid=1 and out_row_sel = 0..ROWS-1 ascending.
- DONE: done=1 for 1 cycle, busy still 1, then IDLE.
- start while busy: ignored, no err.
- reset mid-job: next cycle all outputs 0 and state IDLE; no done is issued; the aborted job is not resumed.
- K=1: every a_rd_en/b_rd_en lane is high for one cycle; the timing formulas above still hold.
- K at max (2^K_W-1): t must not wrap, which is why t is K_W+1 bits.
- Done pulses for PEs on the same anti-diagonal (equal i+j) are asserted in the same cycle.

Optional Feature:
- Macro SYSTOLIC_SEQ_PERF_CNT_EN.
- When defined, add output last_job_cycles [31:0].
  - It is updated in the DONE cycle with the count of cycles from CLEAR through DONE inclusive.
  - Reset value is 0.
  - It holds across idle periods and is not updated on an aborted job.
  - The internal counter saturates at 2^32-1.
- When not defined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Defaults, K=8, start pulsed in cycle 0:
  - pe_clear high in cycle 1.
  - a_rd_en[0] high in cycles 2-9; a_rd_en[3] high in cycles 5-12.
  - pe_done_flag[0] in cycle 12; pe_done_flag[15] in cycle 18.
  - DRAIN in cycles 19-28; out_valid in cycles 29-32 with row sel 0,1,2,3.
  - done in cycle 33; busy high in cycles 1-33.
- k_len=0 with start -> err pulse one cycle later; busy stays 0; no pe_clear.
- start held high continuously through the K=8 job -> no second job while busy; a new job's CLEAR occurs in cycle 35 (IDLE in cycle 34, start sampled there).
- reset asserted in cycle 10 of the K=8 job -> in cycle 11 all outputs are 0; no done pulse; a subsequent start runs a full clean job.
- K=1 -> each rd_en lane high for exactly 1 cycle (lane 0 in cycle 2); pe_done_flag[0] in cycle 5; done in cycle 26.
- With SYSTOLIC_SEQ_PERF_CNT_EN defined, K=8 -> last_job_cycles=33 from cycle 34 onward; the value is unchanged after an aborted job.

Source files
------------

// File: rtl/systolic_pe_sequencer_if.sv
// rtl/systolic_pe_sequencer_if.sv - job/array bundle of the systolic PE sequencer.
// last_job_cycles exists only when SYSTOLIC_SEQ_PERF_CNT_EN is defined.
interface systolic_pe_sequencer_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_W  = 16
);
  localparam int RSW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                 start;
  logic [K_W-1:0]       k_len;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 pe_clear;
  logic [ROWS-1:0]      a_rd_en;
  logic [COLS-1:0]      b_rd_en;
  logic [ROWS*COLS-1:0] pe_done_flag;
  logic                 out_valid;
  logic [RSW-1:0]       out_row_sel;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0]          last_job_cycles;

  modport master (
    output start, k_len,
    input  busy, done, err, pe_clear, a_rd_en, b_rd_en, pe_done_flag,
           out_valid, out_row_sel, last_job_cycles
  );
  modport slave (
    input  start, k_len,
    output busy, done, err, pe_clear, a_rd_en, b_rd_en, pe_done_flag,
           out_valid, out_row_sel, last_job_cycles
  );
`else
  modport master (
    output start, k_len,
    input  busy, done, err, pe_clear, a_rd_en, b_rd_en, pe_done_flag,
           out_valid, out_row_sel
  );
  modport slave (
    input  start, k_len,
    output busy, done, err, pe_clear, a_rd_en, b_rd_en, pe_done_flag,
           out_valid, out_row_sel
  );
`endif
endinterface

// File: rtl/systolic_pe_sequencer.sv
// rtl/systolic_pe_sequencer.sv - clear/feed/drain/readout sequencer for a systolic fp16 MAC grid.
// Optional job cycle counter enabled by SYSTOLIC_SEQ_PERF_CNT_EN.
module systolic_pe_sequencer #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int K_W          = 16,
  parameter int PIPE_STAGE   = 2,
  parameter int DONE_OFFSET  = 3,
  parameter int DRAIN_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  systolic_pe_sequencer_if.slave bus
);
  // One extra bit so t never wraps for the largest k_len.
  localparam int TW  = K_W + 1;
  localparam int RSW = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (DONE_OFFSET <= PIPE_STAGE) begin : g_bad_offset
    $error("DONE_OFFSET must exceed the PE multiplier pipeline depth");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ, S_DONE
  } state_t;

  state_t               r_state;
  logic [K_W-1:0]       r_k;
  logic [TW-1:0]        r_t;
  logic [TW-1:0]        w_t_next;
  logic [TW-1:0]        w_t_last;
  logic [ROWS-1:0]      w_a_en;
  logic [COLS-1:0]      w_b_en;
  logic [ROWS*COLS-1:0] w_flag;

  function automatic logic in_window(input logic [TW-1:0] t, input logic [K_W-1:0] k,
                                     input int lane);
    logic [TW:0] tx, lo, hi;
    tx = {1'b0, t};
    lo = (TW+1)'(lane);
    hi = {2'b00, k} + lo - (TW+1)'(1);
    return (tx >= lo) && (tx <= hi);
  endfunction

  // Enables are computed for the t of the coming cycle so they can be registered.
  assign w_t_next = (r_state == S_FEED) ? r_t + TW'(1) : '0;
  assign w_t_last = {1'b0, r_k} + TW'(DONE_OFFSET + ROWS + COLS - 3);

  always_comb begin
    w_a_en = '0;
    w_b_en = '0;
    w_flag = '0;
    for (int i = 0; i < ROWS; i++) w_a_en[i] = in_window(w_t_next, r_k, i);
    for (int j = 0; j < COLS; j++) w_b_en[j] = in_window(w_t_next, r_k, j);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        w_flag[i*COLS+j] = ({1'b0, w_t_next} == {2'b00, r_k} + (TW+1)'(DONE_OFFSET + i + j - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_k              <= '0;
      r_t              <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
      bus.pe_clear     <= 1'b0;
      bus.a_rd_en      <= '0;
      bus.b_rd_en      <= '0;
      bus.pe_done_flag <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_row_sel  <= '0;
    end else begin
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
      bus.pe_clear     <= 1'b0;
      bus.a_rd_en      <= '0;
      bus.b_rd_en      <= '0;
      bus.pe_done_flag <= '0;
      bus.out_valid    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.k_len != '0) begin
              r_k          <= bus.k_len;
              r_state      <= S_CLEAR;
              bus.pe_clear <= 1'b1;
              bus.busy     <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_state          <= S_FEED;
          r_t              <= '0;
          bus.a_rd_en      <= w_a_en;
          bus.b_rd_en      <= w_b_en;
          bus.pe_done_flag <= w_flag;
        end
        S_FEED: begin
          if (r_t == w_t_last) begin
            r_state <= S_DRAIN;
            r_t     <= '0;
          end else begin
            r_t              <= w_t_next;
            bus.a_rd_en      <= w_a_en;
            bus.b_rd_en      <= w_b_en;
            bus.pe_done_flag <= w_flag;
          end
        end
        S_DRAIN: begin
          // r_t is reused as the drain counter.
          if (r_t == TW'(DRAIN_CYCLES - 1)) begin
            r_state         <= S_READ;
            bus.out_valid   <= 1'b1;
            bus.out_row_sel <= '0;
          end else begin
            r_t <= r_t + TW'(1);
          end
        end
        S_READ: begin
          if (bus.out_row_sel == RSW'(ROWS - 1)) begin
            r_state         <= S_DONE;
            bus.done        <= 1'b1;
            bus.out_row_sel <= '0;
          end else begin
            bus.out_valid   <= 1'b1;
            bus.out_row_sel <= bus.out_row_sel + RSW'(1);
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0] r_cyc;

  // Preloaded to 1 in IDLE so the CLEAR cycle is already counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc               <= '0;
      bus.last_job_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      r_cyc <= 32'd1;
    end else begin
      if (r_cyc != 32'hFFFF_FFFF) r_cyc <= r_cyc + 32'd1;
      if (r_state == S_DONE) bus.last_job_cycles <= r_cyc;
    end
  end
`endif
endmodule
